// File: rtl/seg_time_decoder.sv
// Monitors the six 7-segment digit buses of a clock display, debounces them, decodes
// each accepted pattern to BCD and flags any step that is not exactly +1 s.
module seg_time_decoder #(
  parameter int STABLE_CYCLES = 2,
  parameter bit ACTIVE_LOW    = 1'b0,
  parameter int ERR_W         = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       sec_ones_seg,
  input  logic [6:0]       sec_tens_seg,
  input  logic [6:0]       min_ones_seg,
  input  logic [6:0]       min_tens_seg,
  input  logic [6:0]       hour_ones_seg,
  input  logic [6:0]       hour_tens_seg,
  input  logic             clear_err,
  output logic [23:0]      time_bcd,
  output logic             time_strobe,
  output logic             step_err,
  output logic             invalid,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);

  localparam int CW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0] STAB_MAX = CW'(STABLE_CYCLES);

  typedef enum logic {ACQUIRE = 1'b0, TRACK = 1'b1} state_t;

  state_t        state;
  logic [41:0]   seg_in, seg_q, last_raw;
  logic [CW-1:0] stab_cnt;
  logic          attempted;
  logic [3:0]    dig [6];
  logic [4:0]    dec_r;
  logic          all_ok, legal, accept;
  logic [23:0]   dec_bcd, next_bcd;
  logic [3:0]    so, st, mo, mt, ho, ht;
  logic [3:0]    n_so, n_st, n_mo, n_mt, n_ho, n_ht;

  assign seg_in = {hour_tens_seg, hour_ones_seg, min_tens_seg,
                   min_ones_seg, sec_tens_seg, sec_ones_seg};

  // Returns {digit_ok, bcd}; polarity is normalised before the table lookup.
  function automatic logic [4:0] decode_digit(input logic [6:0] seg);
    logic [6:0] s;
    s = ACTIVE_LOW ? ~seg : seg;
    case (s)
      7'h3F:   return {1'b1, 4'd0};
      7'h06:   return {1'b1, 4'd1};
      7'h5B:   return {1'b1, 4'd2};
      7'h4F:   return {1'b1, 4'd3};
      7'h66:   return {1'b1, 4'd4};
      7'h6D:   return {1'b1, 4'd5};
      7'h7D:   return {1'b1, 4'd6};
      7'h07:   return {1'b1, 4'd7};
      7'h7F:   return {1'b1, 4'd8};
      7'h6F:   return {1'b1, 4'd9};
      default: return 5'd0;
    endcase
  endfunction

  // NOTE: every signal written in a combinational block gets a value on every path,
  // otherwise synthesis infers a latch to hold the old value.
  always_comb begin
    all_ok = 1'b1;
    dec_r  = 5'd0;
    for (int i = 0; i < 6; i++) begin
      dec_r  = decode_digit(seg_q[i*7 +: 7]);
      dig[i] = dec_r[3:0];
      all_ok = all_ok & dec_r[4];
    end
    dec_bcd = {dig[5], dig[4], dig[3], dig[2], dig[1], dig[0]};
    legal   = all_ok && (dig[1] <= 4'd5) && (dig[3] <= 4'd5) &&
              ((dig[5] < 4'd2) || ((dig[5] == 4'd2) && (dig[4] <= 4'd3)));
  end

  // Expected successor of the last accepted time, one second later.
  assign {ht, ho, mt, mo, st, so} = time_bcd;

  always_comb begin
    {n_ht, n_ho, n_mt, n_mo, n_st, n_so} = time_bcd;
    if (so != 4'd9) n_so = so + 4'd1;
    else begin
      n_so = 4'd0;
      if (st != 4'd5) n_st = st + 4'd1;
      else begin
        n_st = 4'd0;
        if (mo != 4'd9) n_mo = mo + 4'd1;
        else begin
          n_mo = 4'd0;
          if (mt != 4'd5) n_mt = mt + 4'd1;
          else begin
            n_mt = 4'd0;
            if (ht == 4'd2 && ho == 4'd3) begin
              n_ht = 4'd0;
              n_ho = 4'd0;
            end else if (ho == 4'd9) begin
              n_ho = 4'd0;
              n_ht = ht + 4'd1;
            end else begin
              n_ho = ho + 4'd1;
            end
          end
        end
      end
    end
    next_bcd = {n_ht, n_ho, n_mt, n_mo, n_st, n_so};
  end

  assign accept = (stab_cnt == STAB_MAX) &&
                  ((seg_q != last_raw) || (state == ACQUIRE && !attempted));
  assign locked = (state == TRACK);

  // NOTE: all state updates use non-blocking assignments so every register sees the
  // pre-edge values of the others, matching real flip-flop behaviour.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ACQUIRE;
      seg_q       <= '0;
      last_raw    <= '0;
      stab_cnt    <= '0;
      attempted   <= 1'b0;
      time_bcd    <= '0;
      time_strobe <= 1'b0;
      step_err    <= 1'b0;
      invalid     <= 1'b0;
      err_count   <= '0;
    end else begin
      seg_q <= seg_in;
      if (seg_in != seg_q)          stab_cnt <= CW'(1);
      else if (stab_cnt != STAB_MAX) stab_cnt <= stab_cnt + CW'(1);

      time_strobe <= 1'b0;
      step_err    <= 1'b0;
      invalid     <= 1'b0;

      if (clear_err) begin
        // The coincident sample is dropped and the next stable one is re-evaluated.
        err_count <= '0;
        state     <= ACQUIRE;
        attempted <= 1'b0;
      end else if (accept) begin
        last_raw <= seg_q;
        if (legal) begin
          time_bcd    <= dec_bcd;
          time_strobe <= 1'b1;
          state       <= TRACK;
          if (state == TRACK && dec_bcd != next_bcd) begin
            step_err <= 1'b1;
            if (err_count != '1) err_count <= err_count + 1'b1;
          end
        end else begin
          invalid   <= 1'b1;
          state     <= ACQUIRE;
          attempted <= 1'b1;
          if (err_count != '1) err_count <= err_count + 1'b1;
        end
      end
    end
  end

endmodule
